// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the word-copy DMA: FSM state codes, status codes and default sizes.
package mem_copy_dma_pkg;

    localparam int unsigned DEPTH_DEFAULT = 1024;
    localparam int unsigned DW_DEFAULT    = 32;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned LEN_W         = 11;
    localparam int unsigned SUM_W         = ADDR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_RANGE = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;

endpackage

// File: rtl/mem_copy_dma.sv
// Single-port RAM word copier: alternating READ/WRITE cycles, ascending addresses,
// range check at start, abort support. All outputs are registered from next-state values.
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned DW    = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    input  logic [DW-1:0]     mem_rdata
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_d;
    logic [DW-1:0]     buf_q, buf_d;
    logic [1:0]        status_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DW-1:0]     mem_wdata_d;
    logic [SUM_W-1:0]  src_end_c;
    logic [SUM_W-1:0]  dst_end_c;

    // Next-state, datapath and memory-port decode
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        cnt_d       = words_done;
        buf_d       = buf_q;
        status_d    = status;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        src_end_c   = {1'b0, src_addr} + SUM_W'(len);
        dst_end_c   = {1'b0, dst_addr} + SUM_W'(len);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if ((src_end_c > SUM_W'(DEPTH)) || (dst_end_c > SUM_W'(DEPTH))) begin
                        status_d = ST_RANGE;
                        state_d  = S_FIN;
                    end else if (len == '0) begin
                        status_d = ST_OK;
                        state_d  = S_FIN;
                    end else begin
                        src_d    = src_addr;
                        dst_d    = dst_addr;
                        len_d    = len;
                        status_d = ST_OK;
                        state_d  = S_READ;
                    end
                end
            end
            S_READ: begin
                buf_d = mem_rdata;
                if (abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_FIN;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // The write strobed this cycle commits regardless of abort
                src_d = src_q + ADDR_W'(1);
                dst_d = dst_q + ADDR_W'(1);
                cnt_d = words_done + LEN_W'(1);
                if (abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_FIN;
                end else if (cnt_d == len_q) begin
                    status_d = ST_OK;
                    state_d  = S_FIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_READ) begin
            mem_addr_d = src_d;
        end else if (state_d == S_WRITE) begin
            mem_addr_d  = dst_d;
            mem_wdata_d = buf_d;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            src_q            <= '0;
            dst_q            <= '0;
            len_q            <= '0;
            buf_q            <= '0;
            words_done       <= '0;
            status           <= ST_OK;
            busy             <= 1'b0;
            done             <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
        end else begin
            state_q          <= state_d;
            src_q            <= src_d;
            dst_q            <= dst_d;
            len_q            <= len_d;
            buf_q            <= buf_d;
            words_done       <= cnt_d;
            status           <= status_d;
            busy             <= (state_d == S_READ) || (state_d == S_WRITE);
            done             <= (state_d == S_FIN);
            mem_addr         <= mem_addr_d;
            mem_wdata        <= mem_wdata_d;
            mem_read_enable  <= (state_d == S_READ);
            mem_write_enable <= (state_d == S_WRITE);
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: behavioural 1024x32 RAM plus an array-level copy model.
module tb_mem_copy_dma;

    localparam int DEPTH   = 1024;
    localparam int MAX_CYC = 2200;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [10:0] len;
    logic        abort;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [10:0] words_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_rdata;

    logic [31:0] ram   [DEPTH];
    logic [31:0] model [DEPTH];

    logic        pre_fill = 1'b0;
    logic        pre_we   = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] fill_seed = '0;

    int total = 0;
    int bad   = 0;
    int both_cnt = 0;

    int          r_cyc, r_busy, r_reads, r_writes;
    logic        r_timeout, r_fin_mem;
    logic [1:0]  r_status;
    logic [10:0] r_wd;

    always #5 clk = ~clk;

    mem_copy_dma dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .len              (len),
        .abort            (abort),
        .busy             (busy),
        .done             (done),
        .status           (status),
        .words_done       (words_done),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_rdata        (mem_rdata)
    );

    function automatic logic [31:0] fill_val(input int k, input logic [31:0] seed);
        return (32'(k) * 32'h9E37_79B1) ^ seed;
    endfunction

    // RAM: combinational read, write on rising edge; bench preload shares the write process
    assign mem_rdata = ram[mem_addr[9:0]];
    always @(posedge clk) begin
        if (pre_fill) begin
            for (int k = 0; k < DEPTH; k++) ram[k] <= fill_val(k, fill_seed);
        end else if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_write_enable) begin
            ram[mem_addr[9:0]] <= mem_wdata;
        end
    end

    always @(negedge clk) if (mem_read_enable && mem_write_enable) both_cnt++;

    task automatic fill_ram();
        @(negedge clk);
        fill_seed = $urandom;
        pre_fill  = 1'b1;
        @(negedge clk);
        pre_fill  = 1'b0;
        for (int k = 0; k < DEPTH; k++) model[k] = fill_val(k, fill_seed);
    endtask

    task automatic poke(input int a, input logic [31:0] v);
        @(negedge clk);
        pre_addr = 10'(a);
        pre_data = v;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
        model[a] = v;
    endtask

    // Reference copy: ascending word-by-word, so forward overlaps propagate
    task automatic model_copy(input int s, input int d, input int k);
        for (int i = 0; i < k; i++) model[d + i] = model[s + i];
    endtask

    function automatic int first_diff();
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== model[i]) return i;
        return -1;
    endfunction

    task automatic run_copy(input int s, input int d, input int n, input int abort_rd,
                            input int abort_wr, input int spur_cyc, input bit abort_with_start);
        @(negedge clk);
        src_addr = 32'(s);
        dst_addr = 32'(d);
        len      = 11'(n);
        start    = 1'b1;
        abort    = abort_with_start;
        r_busy = 0; r_reads = 0; r_writes = 0;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        r_cyc = 1;
        while (!done && r_cyc < MAX_CYC) begin
            if (busy) r_busy++;
            if (mem_read_enable) r_reads++;
            if (mem_write_enable) r_writes++;
            abort = (abort_rd > 0 && mem_read_enable && r_reads == abort_rd) ||
                    (abort_wr > 0 && mem_write_enable && r_writes == abort_wr);
            start = (spur_cyc > 0 && r_cyc == spur_cyc);
            if (start) begin
                src_addr = 32'd500;
                dst_addr = 32'd600;
                len      = 11'd2;
            end
            @(negedge clk);
            r_cyc++;
        end
        start     = 1'b0;
        abort     = 1'b0;
        r_timeout = !done;
        r_status  = status;
        r_wd      = words_done;
        r_fin_mem = mem_read_enable | mem_write_enable | (|mem_addr) | (|mem_wdata);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (status !== 2'b00) begin bad++; $display("FAIL reset_status got=%b want=00", status); end
        total++; if (words_done !== 11'd0) begin bad++; $display("FAIL reset_words got=%0d want=0", words_done); end
        total++; if ({mem_addr, mem_wdata, mem_read_enable, mem_write_enable} !== '0) begin
            bad++; $display("FAIL reset_mem addr=%h wdata=%h re=%b we=%b want all 0",
                            mem_addr, mem_wdata, mem_read_enable, mem_write_enable);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int diff;
        fill_ram();
        run_copy(0, 100, 4, 0, 0, 0, 1'b0);
        model_copy(0, 100, 4);
        total++; if (r_timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout no done within %0d cycles", MAX_CYC); end
        total++; if (r_cyc !== 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", r_cyc); end
        total++; if (r_status !== 2'b00) begin bad++; $display("FAIL basic_status got=%b want=00", r_status); end
        total++; if (r_wd !== 11'd4) begin bad++; $display("FAIL basic_words got=%0d want=4", r_wd); end
        total++; if (r_busy !== 8) begin bad++; $display("FAIL basic_busy got=%0d cycles want=8", r_busy); end
        total++; if (r_reads !== 4 || r_writes !== 4) begin
            bad++; $display("FAIL basic_strobes reads=%0d writes=%0d want 4/4", r_reads, r_writes);
        end
        total++; if (r_fin_mem !== 1'b0) begin bad++; $display("FAIL basic_fin_mem got=%b want=0", r_fin_mem); end
        diff = first_diff();
        total++; if (diff !== -1) begin
            bad++; $display("FAIL basic_ram at=%0d got=%h want=%h", diff, ram[diff], model[diff]);
        end
    endtask

    task automatic test_range();
        int diff;
        run_copy(1000, 0, 30, 0, 0, 0, 1'b0);
        total++; if (r_cyc !== 1 || r_status !== 2'b01) begin
            bad++; $display("FAIL range_src cyc=%0d status=%b want 1/01", r_cyc, r_status);
        end
        total++; if (r_reads !== 0 || r_writes !== 0) begin
            bad++; $display("FAIL range_strobes reads=%0d writes=%0d want 0/0", r_reads, r_writes);
        end
        run_copy(0, 1000, 25, 0, 0, 0, 1'b0);
        total++; if (r_cyc !== 1 || r_status !== 2'b01 || r_wd !== 11'd0) begin
            bad++; $display("FAIL range_dst cyc=%0d status=%b words=%0d want 1/01/0", r_cyc, r_status, r_wd);
        end
        run_copy(0, 0, 1025, 0, 0, 0, 1'b0);
        total++; if (r_status !== 2'b01) begin bad++; $display("FAIL range_len1025 status=%b want=01", r_status); end
        run_copy(1000, 10, 24, 0, 0, 0, 1'b0);
        model_copy(1000, 10, 24);
        total++; if (r_cyc !== 49 || r_status !== 2'b00 || r_wd !== 11'd24) begin
            bad++; $display("FAIL range_edge cyc=%0d status=%b words=%0d want 49/00/24", r_cyc, r_status, r_wd);
        end
        run_copy(0, 0, 1024, 0, 0, 0, 1'b0);
        total++; if (r_cyc !== 2049 || r_status !== 2'b00 || r_wd !== 11'd1024) begin
            bad++; $display("FAIL range_full cyc=%0d status=%b words=%0d want 2049/00/1024", r_cyc, r_status, r_wd);
        end
        diff = first_diff();
        total++; if (diff !== -1) begin
            bad++; $display("FAIL range_ram at=%0d got=%h want=%h", diff, ram[diff], model[diff]);
        end
    endtask

    task automatic test_zero_len();
        run_copy(0, 0, 0, 0, 0, 0, 1'b0);
        total++; if (r_cyc !== 1 || r_status !== 2'b00 || r_wd !== 11'd0) begin
            bad++; $display("FAIL zero_len cyc=%0d status=%b words=%0d want 1/00/0", r_cyc, r_status, r_wd);
        end
        total++; if (r_reads !== 0 || r_writes !== 0) begin
            bad++; $display("FAIL zero_strobes reads=%0d writes=%0d want 0/0", r_reads, r_writes);
        end
    endtask

    task automatic test_abort();
        int diff;
        run_copy(0, 200, 8, 0, 3, 0, 1'b0);
        model_copy(0, 200, 3);
        total++; if (r_status !== 2'b10 || r_wd !== 11'd3 || r_cyc !== 7) begin
            bad++; $display("FAIL abort_write status=%b words=%0d cyc=%0d want 10/3/7", r_status, r_wd, r_cyc);
        end
        run_copy(20, 300, 5, 2, 0, 0, 1'b0);
        model_copy(20, 300, 1);
        total++; if (r_status !== 2'b10 || r_wd !== 11'd1 || r_cyc !== 4) begin
            bad++; $display("FAIL abort_read status=%b words=%0d cyc=%0d want 10/1/4", r_status, r_wd, r_cyc);
        end
        diff = first_diff();
        total++; if (diff !== -1) begin
            bad++; $display("FAIL abort_ram at=%0d got=%h want=%h", diff, ram[diff], model[diff]);
        end
    endtask

    task automatic test_ignored();
        int seen;
        int diff;
        seen = 0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL idle_abort activity=%0d want=0", seen); end
        run_copy(40, 400, 6, 0, 0, 3, 1'b0);
        model_copy(40, 400, 6);
        total++; if (r_cyc !== 13 || r_wd !== 11'd6 || r_status !== 2'b00) begin
            bad++; $display("FAIL busy_start cyc=%0d words=%0d status=%b want 13/6/00", r_cyc, r_wd, r_status);
        end
        run_copy(60, 700, 3, 0, 0, 0, 1'b1);
        model_copy(60, 700, 3);
        total++; if (r_cyc !== 7 || r_wd !== 11'd3 || r_status !== 2'b00) begin
            bad++; $display("FAIL start_abort cyc=%0d words=%0d status=%b want 7/3/00", r_cyc, r_wd, r_status);
        end
        diff = first_diff();
        total++; if (diff !== -1) begin
            bad++; $display("FAIL ignored_ram at=%0d got=%h want=%h", diff, ram[diff], model[diff]);
        end
    endtask

    task automatic test_overlap_reset();
        logic [31:0] x;
        int seen;
        x = $urandom;
        poke(0, x);
        run_copy(0, 1, 3, 0, 0, 0, 1'b0);
        model_copy(0, 1, 3);
        for (int i = 1; i <= 3; i++) begin
            total++; if (ram[i] !== x) begin bad++; $display("FAIL overlap_word%0d got=%h want=%h", i, ram[i], x); end
        end
        @(negedge clk);
        src_addr = 32'd0; dst_addr = 32'd500; len = 11'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy got=%b want=1", busy); end
        #2 reset = 1'b0;
        #1;
        total++; if ({busy, done, status, words_done, mem_addr, mem_wdata, mem_read_enable, mem_write_enable} !== '0) begin
            bad++; $display("FAIL midreset_outputs busy=%b done=%b status=%b words=%0d addr=%h re=%b we=%b want all 0",
                            busy, done, status, words_done, mem_addr, mem_read_enable, mem_write_enable);
        end
        seen = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midreset_nodone activity=%0d want=0", seen); end
    endtask

    task automatic test_random();
        int s, d, n, exp_cyc, diff;
        bit ok;
        fill_ram();
        for (int it = 0; it < 14; it++) begin
            n = $urandom_range(0, 40);
            if ($urandom_range(0, 4) == 0) begin
                s = $urandom_range(DEPTH - 40, DEPTH - 1);
                n = $urandom_range(41, 60);
            end else begin
                s = $urandom_range(0, DEPTH - 41);
            end
            d  = $urandom_range(0, DEPTH - 41);
            ok = (s + n <= DEPTH) && (d + n <= DEPTH);
            exp_cyc = (ok && n > 0) ? 2 * n + 1 : 1;
            run_copy(s, d, n, 0, 0, 0, 1'b0);
            if (ok) model_copy(s, d, n);
            total++; if (r_cyc !== exp_cyc || r_status !== (ok ? 2'b00 : 2'b01) ||
                         r_wd !== (ok ? 11'(n) : 11'd0) || r_busy !== exp_cyc - 1) begin
                bad++; $display("FAIL rand%0d s=%0d d=%0d n=%0d cyc=%0d status=%b words=%0d busy=%0d want cyc=%0d ok=%0d",
                                it, s, d, n, r_cyc, r_status, r_wd, r_busy, exp_cyc, ok);
            end
            diff = first_diff();
            total++; if (diff !== -1) begin
                bad++; $display("FAIL rand%0d_ram at=%0d got=%h want=%h", it, diff, ram[diff], model[diff]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_zero_len();
        test_abort();
        test_ignored();
        test_overlap_reset();
        test_random();
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL both_strobes cycles=%0d want=0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter DEPTH, 1024, number of 32-bit words in the attached RAM; legal word addresses are 0..DEPTH-1.
REQ-002 Parameter DW, 32, data width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src_addr  input  32  first source word address, sampled with start.
REQ-007 dst_addr  input  32  first destination word address, sampled with start.
REQ-008 len  input  11  word count 0..1024, sampled with start.
REQ-009 abort  input  1  terminate an active copy.
REQ-010 busy  output  1  high from the cycle after an accepted start until the cycle before done.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 status  output  2  valid with done and held until next accepted start: 00 ok, 01 range error, 10 aborted.
REQ-013 words_done  output  11  count of words written in the current or last transfer.
REQ-014 mem_addr  output  32  RAM address.
REQ-015 mem_wdata  output  DW  RAM write data.
REQ-016 mem_read_enable  output  1  RAM read strobe.
REQ-017 mem_write_enable  output  1  RAM write strobe; the RAM commits on the rising edge at which it is high.
REQ-018 mem_rdata  input  DW  RAM read data, combinationally valid in the same cycle as mem_read_enable and mem_addr.

Function
REQ-019 FSM states: IDLE, READ, WRITE, FIN; FIN lasts exactly one cycle and asserts done.
REQ-020 IDLE + start: if src_addr+len > DEPTH or dst_addr+len > DEPTH (computed 33-bit, no wrap), go to FIN with status 01 and no RAM access.
REQ-021 IDLE + start, len==0, in range: go to FIN with status 00, no RAM access.
REQ-022 IDLE + start, len>0, in range: latch src/dst/len, clear words_done, go to READ.
REQ-023 READ: mem_addr=src pointer, mem_read_enable=1; at clock edge capture mem_rdata into the word buffer, go to WRITE.
REQ-024 WRITE: mem_addr=dst pointer, mem_wdata=buffer, mem_write_enable=1; at edge increment both pointers and words_done; go to FIN (status 00) if words_done+1==len, else READ.
REQ-025 Throughput: exactly 2 cycles per word; a len=N copy has done at cycle 2N+1 after the start cycle.
REQ-026 Memory outputs are decoded from registered state only; in IDLE and FIN mem_read_enable=mem_write_enable=0, mem_addr=0, mem_wdata=0.
REQ-027 mem_read_enable and mem_write_enable never both high.
REQ-028 Copy order is strictly ascending; overlapping regions with dst>src propagate earlier-copied words (defined behaviour, no detection).
REQ-029 abort in READ or WRITE: go to FIN with status 10; a write strobed in that same cycle still commits and is counted in words_done.
REQ-030 abort in IDLE or FIN is ignored; start outside IDLE is ignored.
REQ-031 Simultaneous start and abort in IDLE: start accepted, abort ignored.

Reset
REQ-032 On reset low: state IDLE, busy=0, done=0, status=00, words_done=0, pointers and buffer 0, all memory outputs 0, asynchronously.
REQ-033 Reset mid-transfer abandons the transfer without a done pulse; a write in flight at the reset edge is not guaranteed.

Structure
REQ-034 Shared package holds the state enum, status encodings (ST_OK, ST_RANGE, ST_ABORT) and the default DEPTH.
REQ-035 Single flat module; no sub-modules.

Verification
REQ-036 Bench pairs the block with a behavioural 1024x32 RAM (combinational read, write on clock edge).
REQ-037 Preload words 0..3 = A0..A3, start src=0 dst=100 len=4 -> done at cycle 9, status 00, words_done 4, RAM[100..103]=A0..A3.
REQ-038 start src=1000 dst=0 len=30 -> done next cycle, status 01, no read/write strobe observed.
REQ-039 start src=0 dst=0 len=0 -> done next cycle, status 00, words_done 0.
REQ-040 start len=8, assert abort in the 3rd WRITE cycle -> status 10, words_done 3, only 3 destination words changed.
REQ-041 start src=0 dst=1 len=3 with RAM[0]=X -> RAM[1..3]=X (forward overlap); assert reset during a second copy -> all outputs 0 immediately, no done.
